mp_burst_memory: RTL and testbench

Parametrised N-port on-chip memory with a round-robin arbiter and true incrementing bursts, serving CPU, NPU and DMA initiators. Each initiator has a valid/ready request channel and a response channel. A single-ported word array is time-shared by a grant/lock state machine, one word access per cycle. Bursts of 1–16 beats stream one word per cycle.

---
 rtl/mp_burst_memory_if.sv | 40 ++++
 rtl/mp_burst_memory.sv | 233 +++++++++++++++++++++++
 tb/tb_mp_burst_memory.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_burst_memory_if.sv
// Request/response bundle between N initiators and mp_burst_memory.
// rsp_err exists only when MPMEM_ERR_EN is defined.
interface mp_burst_memory_if #(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [NPORTS-1:0]        req_valid;
    logic [NPORTS-1:0]        req_ready;
    logic [NPORTS*64-1:0]     req_addr;
    logic [NPORTS-1:0]        req_we;
    logic [NPORTS*4-1:0]      req_len;
    logic [NPORTS*DATA_W-1:0] req_wdata;
    logic [NPORTS*BE_W-1:0]   req_be;
    logic [NPORTS-1:0]        rsp_valid;
    logic [NPORTS*DATA_W-1:0] rsp_data;
    logic [NPORTS-1:0]        rsp_last;
`ifdef MPMEM_ERR_EN
    logic [NPORTS-1:0]        rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_len, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, req_we, req_len, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
`else
    modport master (
        output req_valid, req_addr, req_we, req_len, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );
    modport slave (
        input  req_valid, req_addr, req_we, req_len, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );
`endif
endinterface

// File: rtl/mp_burst_memory.sv
// N-port burst memory: round-robin arbiter time-sharing one single-ported word array.
// Define MPMEM_ERR_EN for out-of-range error reporting instead of address wrap.
module mp_burst_memory #(
    parameter int unsigned NPORTS   = 2,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned WORDS    = 1024,
    parameter string       MEM_INIT = ""
) (
    input logic              clk,
    input logic              rst_n,
    mp_burst_memory_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned AW    = $clog2(WORDS);
    localparam int unsigned IW    = 64 - OFF_W;
    localparam int unsigned PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   port_q, port_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      beat_q, beat_d;
    logic            wr_err_q, wr_err_d;
    logic            run_q;

    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_last_q, rsp_last_d;
    logic            rsp_rd_q, rsp_rd_d;
    logic            rsp_err_q, rsp_err_d;
    logic [PW-1:0]   rsp_port_q, rsp_port_d;

    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] rd_data_q;
    logic              mem_we, mem_re;
    logic [AW-1:0]     mem_addr;

    logic              gnt_any;
    logic [PW-1:0]     gnt_port;
    logic [NPORTS-1:0] ready;

    logic [PW-1:0]     sel_port;
    logic [63:0]       sel_addr;
    logic              sel_we;
    logic [3:0]        sel_len;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic [IW-1:0]     first_idx;
    logic              first_oob, cur_oob;
    logic              unused_addr_lsb;

    // Round-robin search starting one past the last winner.
    always_comb begin
        int sel;
        sel      = 0;
        gnt_any  = 1'b0;
        gnt_port = '0;
        for (int i = 1; i <= int'(NPORTS); i++) begin
            sel = (int'(rr_ptr_q) + i) % int'(NPORTS);
            if (!gnt_any && bus.req_valid[sel]) begin
                gnt_any  = 1'b1;
                gnt_port = PW'(sel);
            end
        end
    end

    always_comb begin
        sel_port  = (state_q == StIdle) ? gnt_port : port_q;
        sel_addr  = bus.req_addr[int'(sel_port)*64 +: 64];
        sel_we    = bus.req_we[sel_port];
        sel_len   = bus.req_len[int'(sel_port)*4 +: 4];
        sel_wdata = bus.req_wdata[int'(sel_port)*DATA_W +: DATA_W];
        sel_be    = bus.req_be[int'(sel_port)*BE_W +: BE_W];
    end

    assign first_idx       = sel_addr[63:OFF_W];
    assign unused_addr_lsb = ^sel_addr[OFF_W-1:0];

`ifdef MPMEM_ERR_EN
    assign first_oob = |first_idx[IW-1:AW];
    assign cur_oob   = |idx_q[IW-1:AW];
`else
    assign first_oob = 1'b0;
    assign cur_oob   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        port_d      = port_q;
        idx_d       = idx_q;
        len_d       = len_q;
        beat_d      = beat_q;
        wr_err_d    = wr_err_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_rd_d    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_port_d  = rsp_port_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = idx_q[AW-1:0];
        ready       = '0;
        unique case (state_q)
            StIdle: begin
                if (run_q && gnt_any) begin
                    ready[gnt_port] = 1'b1;
                    rr_ptr_d = gnt_port;
                    port_d   = gnt_port;
                    mem_addr = first_idx[AW-1:0];
                    idx_d    = first_idx + 1'b1;
                    len_d    = sel_len;
                    beat_d   = 4'd1;
                    if (sel_we) begin
                        mem_we   = !first_oob;
                        wr_err_d = first_oob;
                        if (sel_len == 4'd0) begin
                            rsp_valid_d = 1'b1;
                            rsp_last_d  = 1'b1;
                            rsp_err_d   = first_oob;
                            rsp_port_d  = gnt_port;
                        end else begin
                            state_d = StWrBurst;
                        end
                    end else begin
                        mem_re      = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_rd_d    = 1'b1;
                        rsp_last_d  = (sel_len == 4'd0);
                        rsp_err_d   = first_oob;
                        rsp_port_d  = gnt_port;
                        if (sel_len != 4'd0) state_d = StRdBurst;
                    end
                end
            end
            StRdBurst: begin
                mem_re      = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_rd_d    = 1'b1;
                rsp_err_d   = cur_oob;
                rsp_port_d  = port_q;
                idx_d       = idx_q + 1'b1;
                beat_d      = beat_q + 4'd1;
                if (beat_q == len_q) begin
                    rsp_last_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            StWrBurst: begin
                ready[port_q] = bus.req_valid[port_q];
                if (bus.req_valid[port_q]) begin
                    mem_we   = !cur_oob;
                    idx_d    = idx_q + 1'b1;
                    beat_d   = beat_q + 4'd1;
                    wr_err_d = wr_err_q | cur_oob;
                    if (beat_q == len_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = 1'b1;
                        rsp_err_d   = wr_err_q | cur_oob;
                        rsp_port_d  = port_q;
                        state_d     = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // run_q holds off grants for the first cycle after reset so nothing is accepted during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= PW'(NPORTS - 1);
            port_q      <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            wr_err_q    <= 1'b0;
            run_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_rd_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_port_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            port_q      <= port_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wr_err_q    <= wr_err_d;
            run_q       <= 1'b1;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            rsp_port_q  <= rsp_port_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (sel_be[b]) mem[mem_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
        if (mem_re) rd_data_q <= mem[mem_addr];
    end

    assign bus.req_ready = ready;

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_last  = '0;
        bus.rsp_data  = '0;
`ifdef MPMEM_ERR_EN
        bus.rsp_err   = '0;
`endif
        if (rsp_valid_q) begin
            bus.rsp_valid[rsp_port_q] = 1'b1;
            bus.rsp_last[rsp_port_q]  = rsp_last_q;
            bus.rsp_data[int'(rsp_port_q)*DATA_W +: DATA_W] =
                (rsp_rd_q && !rsp_err_q) ? rd_data_q : '0;
`ifdef MPMEM_ERR_EN
            bus.rsp_err[rsp_port_q]   = rsp_err_q;
`endif
        end
    end
endmodule

// File: tb/tb_mp_burst_memory.sv
// Directed bench for mp_burst_memory: single/byte-enable/burst access, wrap or error,
// round-robin contention and reset in the middle of a write burst.
module tb_mp_burst_memory;
    localparam int unsigned NPORTS = 2;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned WORDS  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mp_burst_memory_if #(.NPORTS(NPORTS), .DATA_W(DATA_W)) bus ();

    mp_burst_memory #(
        .NPORTS  (NPORTS),
        .DATA_W  (DATA_W),
        .WORDS   (WORDS),
        .MEM_INIT("")
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {int port; int cyc; logic [63:0] data; logic last; logic err;} rsp_t;
    typedef struct {int port; int cyc;} gnt_t;
    rsp_t rsp_q[$];
    gnt_t gnt_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            if (bus.req_valid[p] && bus.req_ready[p]) gnt_q.push_back('{port: p, cyc: cyc});
            if (bus.rsp_valid[p]) begin
                rsp_t r;
                r.port = p;
                r.cyc  = cyc;
                r.data = bus.rsp_data[p*64 +: 64];
                r.last = bus.rsp_last[p];
`ifdef MPMEM_ERR_EN
                r.err  = bus.rsp_err[p];
`else
                r.err  = 1'b0;
`endif
                rsp_q.push_back(r);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rsp_idx(input int port, input int n);
        int seen = 0;
        foreach (rsp_q[i]) begin
            if (rsp_q[i].port == port) begin
                if (seen == n) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int rsp_count(input int port);
        int c = 0;
        foreach (rsp_q[i]) if (rsp_q[i].port == port) c++;
        return c;
    endfunction

    function automatic int gnt_cyc(input int port, input bit last);
        int c = -1;
        foreach (gnt_q[i]) if (gnt_q[i].port == port && (last || c < 0)) c = gnt_q[i].cyc;
        return c;
    endfunction

    task automatic check_rsp(input string tag, input int port, input int n, input int exp_cyc,
                             input logic [63:0] exp_data, input logic exp_last,
                             input logic exp_err);
        int i = rsp_idx(port, n);
        check({tag, "_present"}, 64'(i >= 0), 64'(1));
        if (i >= 0) begin
            check({tag, "_cycle"}, 64'(rsp_q[i].cyc), 64'(exp_cyc));
            check({tag, "_data"}, rsp_q[i].data, exp_data);
            check({tag, "_last"}, 64'(rsp_q[i].last), 64'(exp_last));
`ifdef MPMEM_ERR_EN
            check({tag, "_err"}, 64'(rsp_q[i].err), 64'(exp_err));
`else
            check({tag, "_err"}, 64'(rsp_q[i].err | exp_err), 64'(0));
`endif
        end
    endtask

    task automatic clear_logs();
        rsp_q.delete();
        gnt_q.delete();
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Bounded wait for a beat acceptance, sampled on the falling edge.
    task automatic wait_ready(input int p);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready[p] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(bus.req_ready[p]), 64'(1));
    endtask

    // Write beat k carries wdata + k.
    task automatic do_req(input int p, input logic [63:0] addr, input logic we, input int len,
                          input logic [63:0] wdata, input logic [7:0] be);
        bus.req_valid[p]           = 1'b1;
        bus.req_addr[p*64 +: 64]   = addr;
        bus.req_we[p]              = we;
        bus.req_len[p*4 +: 4]      = 4'(len);
        bus.req_wdata[p*64 +: 64]  = wdata;
        bus.req_be[p*8 +: 8]       = be;
        for (int k = 0; k <= (we ? len : 0); k++) begin
            wait_ready(p);
            @(posedge clk);
            #1;
            bus.req_wdata[p*64 +: 64] = wdata + 64'(k + 1);
        end
        bus.req_valid[p] = 1'b0;
    endtask

    initial begin
        int t;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_we    = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;

        // Reset with a request pending: nothing may be granted.
        #2 rst_n = 1'b0;
        bus.req_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(bus.req_ready), 64'(0));
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset_rsp_last", 64'(bus.rsp_last), 64'(0));
        check("reset_rsp_data", 64'(|bus.rsp_data), 64'(0));
`ifdef MPMEM_ERR_EN
        check("reset_rsp_err", 64'(bus.rsp_err), 64'(0));
`endif
        bus.req_valid[0] = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single write then single read.
        clear_logs();
        do_req(0, 64'h40, 1'b1, 0, 64'h1122334455667788, 8'hFF);
        settle();
        check("wr_ack_count", 64'(rsp_count(0)), 64'(1));
        check_rsp("wr_ack", 0, 0, gnt_cyc(0, 1'b1) + 1, 64'h0, 1'b1, 1'b0);
        clear_logs();
        do_req(0, 64'h40, 1'b0, 0, 64'h0, 8'h00);
        settle();
        check("rd_single_count", 64'(rsp_count(0)), 64'(1));
        check_rsp("rd_single", 0, 0, gnt_cyc(0, 1'b0) + 1, 64'h1122334455667788, 1'b1, 1'b0);

        // Byte enables: low four bytes only.
        do_req(0, 64'h80, 1'b1, 0, 64'h0, 8'hFF);
        do_req(0, 64'h80, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        settle();
        clear_logs();
        do_req(0, 64'h80, 1'b0, 0, 64'h0, 8'h00);
        settle();
        check_rsp("rd_be", 0, 0, gnt_cyc(0, 1'b0) + 1, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);

        // Four-beat write burst of 1..4, then four-beat read.
        clear_logs();
        do_req(0, 64'h100, 1'b1, 3, 64'd1, 8'hFF);
        settle();
        check("wr_burst_beats", 64'(gnt_q.size()), 64'(4));
        check("wr_burst_ack_count", 64'(rsp_count(0)), 64'(1));
        check_rsp("wr_burst_ack", 0, 0, gnt_cyc(0, 1'b1) + 1, 64'h0, 1'b1, 1'b0);
        clear_logs();
        do_req(0, 64'h100, 1'b0, 3, 64'h0, 8'h00);
        settle();
        t = gnt_cyc(0, 1'b0);
        check("rd_burst_count", 64'(rsp_count(0)), 64'(4));
        for (int k = 0; k < 4; k++) begin
            check_rsp($sformatf("rd_burst_b%0d", k), 0, k, t + 1 + k, 64'(k + 1), k == 3, 1'b0);
        end

        // Burst starting at the last word.
        do_req(0, 64'h1FF8, 1'b1, 0, 64'hAAAA_5555_0000_1023, 8'hFF);
        do_req(0, 64'h0, 1'b1, 0, 64'hBBBB_6666_0000_0000, 8'hFF);
        settle();
        clear_logs();
        do_req(0, 64'h1FF8, 1'b0, 1, 64'h0, 8'h00);
        settle();
        t = gnt_cyc(0, 1'b0);
        check_rsp("wrap_b0", 0, 0, t + 1, 64'hAAAA_5555_0000_1023, 1'b0, 1'b0);
`ifdef MPMEM_ERR_EN
        check_rsp("wrap_b1", 0, 1, t + 2, 64'h0, 1'b1, 1'b1);
`else
        check_rsp("wrap_b1", 0, 1, t + 2, 64'hBBBB_6666_0000_0000, 1'b1, 1'b0);
`endif

        // Contention: port 0 won last, so port 1 goes first and grants alternate.
        clear_logs();
        fork
            begin
                for (int k = 0; k < 3; k++) do_req(0, 64'h40, 1'b0, 0, 64'h0, 8'h00);
            end
            begin
                for (int k = 0; k < 3; k++) do_req(1, 64'h100, 1'b0, 0, 64'h0, 8'h00);
            end
        join
        settle();
        check("rr_grant_count", 64'(gnt_q.size()), 64'(6));
        for (int i = 0; i < gnt_q.size() && i < 6; i++) begin
            check($sformatf("rr_port_%0d", i), 64'(gnt_q[i].port), 64'((i + 1) % 2));
            if (i > 0) begin
                check($sformatf("rr_cycle_%0d", i), 64'(gnt_q[i].cyc),
                      64'(gnt_q[i-1].cyc + 1));
            end
        end
        check("rr_rsp_p0", 64'(rsp_count(0)), 64'(3));
        check("rr_rsp_p1", 64'(rsp_count(1)), 64'(3));
        check_rsp("rr_p1_first", 1, 0, gnt_cyc(1, 1'b0) + 1, 64'd1, 1'b1, 1'b0);

        // Reset after beat 2 of a 4-beat write; beat 3 must not land.
        do_req(0, 64'h218, 1'b1, 0, 64'hDEAD, 8'hFF);
        settle();
        bus.req_valid[0]          = 1'b1;
        bus.req_addr[63:0]        = 64'h200;
        bus.req_we[0]             = 1'b1;
        bus.req_len[3:0]          = 4'd3;
        bus.req_wdata[63:0]       = 64'h10;
        bus.req_be[7:0]           = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            wait_ready(0);
            @(posedge clk);
            #1;
            bus.req_wdata[63:0] = 64'h10 + 64'(k + 1);
        end
        clear_logs();
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 64'(bus.req_ready), 64'(0));
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("midrst_rsp_last", 64'(bus.rsp_last), 64'(0));
        check("midrst_rsp_data", 64'(|bus.rsp_data), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        rst_n = 1'b1;
        settle();
        check("midrst_no_rsp", 64'(rsp_q.size()), 64'(0));
        clear_logs();
        fork
            do_req(0, 64'h200, 1'b0, 3, 64'h0, 8'h00);
            do_req(1, 64'h40, 1'b0, 0, 64'h0, 8'h00);
        join
        settle();
        check("midrst_first_port", 64'(gnt_q.size() > 0 ? gnt_q[0].port : -1), 64'(0));
        t = gnt_cyc(0, 1'b0);
        check("midrst_p1_no_bubble", 64'(gnt_cyc(1, 1'b0)), 64'(t + 4));
        check_rsp("midrst_b0", 0, 0, t + 1, 64'h10, 1'b0, 1'b0);
        check_rsp("midrst_b1", 0, 1, t + 2, 64'h11, 1'b0, 1'b0);
        check_rsp("midrst_b2", 0, 2, t + 3, 64'h12, 1'b0, 1'b0);
        check_rsp("midrst_b3", 0, 3, t + 4, 64'hDEAD, 1'b1, 1'b0);
        check_rsp("midrst_p1", 1, 0, t + 5, 64'h1122334455667788, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "watchdog expired");
    end
endmodule
